pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_ctrl.
// The datapath side drives hazard sources and consumes enables, flushes and selects.
interface pipeline_ctrl_if;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic        idex_MemRead;
  logic [4:0]  exmem_Dest;
  logic [4:0]  memwb_Dest;
  logic        exmem_RegWrite;
  logic        memwb_RegWrite;
  logic        exmem_MemAccess;
  logic        mem_ready;
  logic        Jump;
  logic        branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  modport master (
    output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_MemRead,
           exmem_Dest, memwb_Dest, exmem_RegWrite, memwb_RegWrite,
           exmem_MemAccess, mem_ready, Jump, branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, fwd_a, fwd_b, stall_cycles, mem_timeout
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_MemRead,
           exmem_Dest, memwb_Dest, exmem_RegWrite, memwb_RegWrite,
           exmem_MemAccess, mem_ready, Jump, branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, fwd_a, fwd_b, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, redirect flush,
// load-use stall, operand forwarding, stall counter and memory-wait watchdog.
module pipeline_ctrl (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_next;
  logic [15:0] r_stall_cycles;
  logic        r_mem_timeout;

  logic w_freeze;
  logic w_redirect;
  logic w_load_use;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_idex_en;
  logic w_exmem_en;
  logic w_memwb_en;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_freeze   = bus.exmem_MemAccess & ~bus.mem_ready;
  assign w_redirect = bus.branch_taken | bus.Jump;
  assign w_load_use = bus.idex_MemRead & (bus.idex_rt != 5'd0) &
                      ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));

  // EX/MEM result is newer than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (bus.exmem_RegWrite && bus.exmem_Dest != 5'd0 && bus.exmem_Dest == src)
      return 2'b10;
    else if (bus.memwb_RegWrite && bus.memwb_Dest != 5'd0 && bus.memwb_Dest == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_fwd_a      = fwd_sel(bus.idex_rs);
    w_fwd_b      = fwd_sel(bus.idex_rt);
    if (rst) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
      w_fwd_a    = 2'b00;
      w_fwd_b    = 2'b00;
    end else if (w_freeze) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (w_redirect) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = bus.branch_taken;
    end else if (w_load_use) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_state_next    = MEMWAIT;
          w_wait_cnt_next = 8'd0;
        end
      end
      MEMWAIT: begin
        if (w_freeze) begin
          if (r_wait_cnt != 8'hFF)
            w_wait_cnt_next = r_wait_cnt + 8'd1;
        end else begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_stall_cycles <= 16'd0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (!w_pc_en && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
      // Only a MEMWAIT increment can land on 255; the flag is sticky.
      if (r_state == MEMWAIT && w_freeze && r_wait_cnt == 8'hFE)
        r_mem_timeout <= 1'b1;
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.ifid_en      = w_ifid_en;
  assign bus.idex_en      = w_idex_en;
  assign bus.exmem_en     = w_exmem_en;
  assign bus.memwb_en     = w_memwb_en;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_flush   = w_idex_flush;
  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a priority/counting model checked every
// negedge, plus literal expectations at each directed step.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();
  pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Model state: stalled-edge tally and length of the current freeze run.
  int m_stall   = 0;
  int m_run     = 0;
  bit m_timeout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output order: pc, ifid, idex, exmem, memwb enables, ifid_flush, idex_flush.
  function automatic logic [6:0] model_ctl();
    bit freeze, redirect, load_use;
    if (rst) return 7'b0000000;
    freeze   = bus.exmem_MemAccess && !bus.mem_ready;
    redirect = bus.branch_taken || bus.Jump;
    load_use = bus.idex_MemRead && bus.idex_rt != 0 &&
               (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
    if (freeze)   return 7'b0000000;
    if (redirect) return {5'b11111, 1'b1, bus.branch_taken};
    if (load_use) return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (rst) return 2'b00;
    if (bus.exmem_RegWrite && bus.exmem_Dest != 0 && bus.exmem_Dest == src) return 2'b10;
    if (bus.memwb_RegWrite && bus.memwb_Dest != 0 && bus.memwb_Dest == src) return 2'b01;
    return 2'b00;
  endfunction

  // Timeout fires on the 256th consecutive frozen edge: the first edge only
  // enters the wait and clears the count, the next 255 count it up to 255.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stall   = 0;
      m_run     = 0;
      m_timeout = 1'b0;
    end else begin
      logic [6:0] c;
      c = model_ctl();
      if (!c[6] && m_stall < 65535) m_stall = m_stall + 1;
      if (bus.exmem_MemAccess && !bus.mem_ready) m_run = m_run + 1;
      else m_run = 0;
      if (m_run >= 256) m_timeout = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ctl_vec", {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                    bus.ifid_flush, bus.idex_flush}, model_ctl());
    chk("fwd_a", bus.fwd_a, model_fwd(bus.idex_rs));
    chk("fwd_b", bus.fwd_b, model_fwd(bus.idex_rt));
    chk("stall_cycles", bus.stall_cycles, m_stall);
    chk("mem_timeout", bus.mem_timeout, m_timeout);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifid_rs = 0; bus.ifid_rt = 0; bus.idex_rs = 0; bus.idex_rt = 0;
    bus.idex_MemRead = 0; bus.exmem_Dest = 0; bus.memwb_Dest = 0;
    bus.exmem_RegWrite = 0; bus.memwb_RegWrite = 0;
    bus.exmem_MemAccess = 0; bus.mem_ready = 0; bus.Jump = 0; bus.branch_taken = 0;
  endtask

  function automatic logic [6:0] ctl_now();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush};
  endfunction

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", ctl_now(), 7'b0000000);
    chk("rst_stall", bus.stall_cycles, 0);
    chk("rst_timeout", bus.mem_timeout, 0);
    $display("txn reset released");
    rst = 1'b0;
    @(negedge clk);
    chk("normal_ctl", ctl_now(), 7'b1111100);

    cyc();
    $display("txn load-use idex_rt=5 ifid_rs=5");
    bus.idex_MemRead = 1; bus.idex_rt = 5; bus.ifid_rs = 5;
    @(negedge clk);
    chk("lu_ctl", ctl_now(), 7'b0011101);
    cyc();
    $display("txn load-use idex_rt=0");
    bus.idex_rt = 0;
    @(negedge clk);
    chk("lu_stall", bus.stall_cycles, 1);
    chk("lu_r0_ctl", ctl_now(), 7'b1111100);
    cyc();
    clear_inputs();
    @(negedge clk);
    chk("lu_r0_stall", bus.stall_cycles, 1);

    cyc();
    $display("txn forward both match");
    bus.exmem_Dest = 7; bus.memwb_Dest = 7; bus.idex_rs = 7;
    bus.exmem_RegWrite = 1; bus.memwb_RegWrite = 1;
    @(negedge clk);
    chk("fwd_a_exmem", bus.fwd_a, 2'b10);
    cyc();
    $display("txn forward memwb only");
    bus.exmem_RegWrite = 0;
    @(negedge clk);
    chk("fwd_a_memwb", bus.fwd_a, 2'b01);
    cyc();
    $display("txn forward dest zero");
    bus.exmem_Dest = 0; bus.memwb_Dest = 0; bus.idex_rs = 0;
    @(negedge clk);
    chk("fwd_a_none", bus.fwd_a, 2'b00);
    cyc();
    $display("txn forward operand b");
    bus.idex_rt = 9; bus.exmem_Dest = 9; bus.memwb_Dest = 9; bus.exmem_RegWrite = 1;
    @(negedge clk);
    chk("fwd_b_exmem", bus.fwd_b, 2'b10);
    chk("fwd_a_idle", bus.fwd_a, 2'b00);
    cyc();
    clear_inputs();

    $display("txn branch taken");
    bus.branch_taken = 1;
    @(negedge clk);
    chk("branch_ctl", ctl_now(), 7'b1111111);
    cyc();
    $display("txn jump");
    bus.branch_taken = 0; bus.Jump = 1;
    @(negedge clk);
    chk("jump_ctl", ctl_now(), 7'b1111110);
    cyc();
    clear_inputs();

    $display("txn memory wait 3 cycles");
    bus.exmem_MemAccess = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_ctl", ctl_now(), 7'b0000000);
      cyc();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    chk("wait_done_ctl", ctl_now(), 7'b1111100);
    chk("wait_stall", bus.stall_cycles, 4);
    chk("wait_timeout", bus.mem_timeout, 0);
    cyc();
    clear_inputs();

    $display("txn freeze + branch + load-use");
    bus.exmem_MemAccess = 1; bus.mem_ready = 0; bus.branch_taken = 1;
    bus.idex_MemRead = 1; bus.idex_rt = 3; bus.ifid_rt = 3;
    @(negedge clk);
    chk("simul_ctl", ctl_now(), 7'b0000000);
    cyc();
    $display("txn freeze released, branch held");
    bus.mem_ready = 1;
    @(negedge clk);
    chk("simul_redirect", ctl_now(), 7'b1111111);
    chk("simul_stall", bus.stall_cycles, 5);
    cyc();
    clear_inputs();

    $display("txn watchdog 300 cycles");
    bus.exmem_MemAccess = 1; bus.mem_ready = 0;
    repeat (255) cyc();
    @(negedge clk);
    chk("wd_before", bus.mem_timeout, 0);
    cyc();
    @(negedge clk);
    chk("wd_set", bus.mem_timeout, 1);
    repeat (44) cyc();
    bus.mem_ready = 1;
    @(negedge clk);
    chk("wd_stall", bus.stall_cycles, 305);
    chk("wd_sticky", bus.mem_timeout, 1);
    cyc();
    @(negedge clk);
    chk("wd_sticky2", bus.mem_timeout, 1);

    $display("txn reset mid memory wait");
    bus.mem_ready = 0; bus.idex_rs = 4; bus.exmem_Dest = 4; bus.exmem_RegWrite = 1;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_timeout", bus.mem_timeout, 0);
    chk("mid_rst_stall", bus.stall_cycles, 0);
    chk("mid_rst_ctl", ctl_now(), 7'b0000000);
    chk("mid_rst_fwd", bus.fwd_a, 2'b00);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_freeze", ctl_now(), 7'b0000000);
    chk("post_rst_fwd", bus.fwd_a, 2'b10);
    cyc();
    @(negedge clk);
    chk("post_rst_stall", bus.stall_cycles, 1);
    chk("post_rst_timeout", bus.mem_timeout, 0);
    cyc();
    clear_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
